pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/rv_pkg.sv | 34 +++
 rtl/hazard_detect.sv | 39 +++
 rtl/pipeline_hazard_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I decode constants, bubble encoding and hazard-controller state encodings.
package rv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_LU_BUBBLE = 2'd1;
    localparam logic [1:0] ST_BR_FLUSH  = 2'd2;
    localparam logic [1:0] ST_MEM_WAIT  = 2'd3;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rv_fields_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags a decode instruction that reads the rd of a load in execute.
module hazard_detect
    import rv_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_INSTR
) (
    input  logic [31:0] id_instr_i,
    input  logic [31:0] ex_instr_i,
    output logic        load_use_o
);

    rv_fields_t id_f;
    rv_fields_t ex_f;
    logic       rs1_used;
    logic       rs2_used;
    logic       ex_load;
    logic       hit_rs1;
    logic       hit_rs2;
    logic       id_bubble;
    logic       unused_fields;

    assign id_f = rv_fields_t'(id_instr_i);
    assign ex_f = rv_fields_t'(ex_instr_i);

    assign rs1_used = (id_f.opcode != OP_LUI) && (id_f.opcode != OP_AUIPC) && (id_f.opcode != OP_JAL);
    assign rs2_used = (id_f.opcode == OP_REG) || (id_f.opcode == OP_STORE) || (id_f.opcode == OP_BRANCH);
    assign ex_load  = (ex_f.opcode == OP_LOAD) && (ex_f.rd != 5'd0);

    assign hit_rs1 = rs1_used && (ex_f.rd == id_f.rs1);
    assign hit_rs2 = rs2_used && (ex_f.rd == id_f.rs2);

    // A bubble in decode reads nothing, whatever its encoding happens to be.
    assign id_bubble  = (id_instr_i == NOP);
    assign load_use_o = ex_load && (hit_rs1 || hit_rs2) && !id_bubble;

    assign unused_fields = ^{id_f.funct7, id_f.funct3, id_f.rd,
                             ex_f.funct7, ex_f.funct3, ex_f.rs1, ex_f.rs2};

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage RV32I pipeline: load-use bubbles, branch flushes,
// data-memory waits, plus saturating stall/flush counters and a sticky wait timeout.
module pipeline_hazard_ctrl
    import rv_pkg::*;
#(
    parameter int          WAIT_MAX = 16,
    parameter logic [31:0] NOP      = NOP_INSTR
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [31:0] id_instr,
    input  logic [31:0] ex_instr,
    input  logic        ex_branch_taken,
    input  logic        mem_busy,
    output logic        stall_pc,
    output logic        stall_ifid,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count,
    output logic        timeout
);

    localparam logic [15:0] WAIT_LIM = 16'(WAIT_MAX);

    logic [1:0]  state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        timeout_q, timeout_d;

    logic load_use;
    logic stall;
    logic flush_if;
    logic flush_id;
    logic redirect;

    hazard_detect #(.NOP(NOP)) u_hazard_detect (
        .id_instr_i (id_instr),
        .ex_instr_i (ex_instr),
        .load_use_o (load_use)
    );

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        stall    = 1'b0;
        flush_if = 1'b0;
        flush_id = 1'b0;
        redirect = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    stall   = 1'b1;
                    wait_d  = 16'd0;
                    state_d = ST_MEM_WAIT;
                end else if (ex_branch_taken) begin
                    flush_if = 1'b1;
                    flush_id = 1'b1;
                    redirect = 1'b1;
                    state_d  = ST_BR_FLUSH;
                end else if (load_use) begin
                    stall    = 1'b1;
                    flush_id = 1'b1;
                    state_d  = ST_LU_BUBBLE;
                end
            end
            ST_LU_BUBBLE: state_d = ST_RUN;
            ST_BR_FLUSH: begin
                // Second cycle of the penalty: the wrong-path fetch now sitting in IF/ID.
                flush_if = 1'b1;
                state_d  = ST_RUN;
            end
            ST_MEM_WAIT: begin
                if (mem_busy) begin
                    stall  = 1'b1;
                    wait_d = sat_inc(wait_q);
                end else begin
                    wait_d  = 16'd0;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign stall_cnt_d = stall    ? sat_inc(stall_cnt_q) : stall_cnt_q;
    assign flush_cnt_d = redirect ? sat_inc(flush_cnt_q) : flush_cnt_q;
    assign timeout_d   = timeout_q || (wait_d > WAIT_LIM);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q     <= ST_RUN;
            wait_q      <= 16'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // State sits in RUN during clear, so the live inputs must be masked off here.
    assign stall_pc     = stall    & ~clear;
    assign stall_ifid   = stall    & ~clear;
    assign flush_ifid   = flush_if & ~clear;
    assign flush_idex   = flush_id & ~clear;
    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
    assign timeout      = timeout_q;

endmodule
